// File: rtl/poolb3_consumer_if.sv
// Ports between poolb3_consumer, the conv layer's finished IFM memory and the next layer's IFM memory.
// master = consumer side, slave = memories/neighbouring layers.
interface poolb3_consumer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE   = 10,
  parameter int IFM_DEPTH  = 16
);
  localparam int IFM_SIZE_NEXT = IFM_SIZE / 2;
  localparam int ADDR_PREV     = $clog2(IFM_SIZE * IFM_SIZE);
  localparam int ADDR_NEXT_RAW = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT);
  localparam int ADDR_NEXT     = (ADDR_NEXT_RAW > 0) ? ADDR_NEXT_RAW : 1;
  localparam int SEL_W         = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;

  logic                  start_from_previous;
  logic                  end_to_previous;
  logic [SEL_W-1:0]      ifm_sel_previous;
  logic                  ifm_enable_read_previous;
  logic [ADDR_PREV-1:0]  ifm_address_read_previous;
  logic [DATA_WIDTH-1:0] data_in_from_previous;
  logic                  end_from_next;
  logic                  start_to_next;
  logic [SEL_W-1:0]      ifm_sel_next;
  logic                  ifm_enable_write_next;
  logic [ADDR_NEXT-1:0]  ifm_address_write_next;
  logic [DATA_WIDTH-1:0] data_out_for_next;

  modport master (
    input  start_from_previous, data_in_from_previous, end_from_next,
    output end_to_previous, ifm_sel_previous, ifm_enable_read_previous, ifm_address_read_previous,
    output start_to_next, ifm_sel_next, ifm_enable_write_next, ifm_address_write_next, data_out_for_next
  );

  modport slave (
    output start_from_previous, data_in_from_previous, end_from_next,
    input  end_to_previous, ifm_sel_previous, ifm_enable_read_previous, ifm_address_read_previous,
    input  start_to_next, ifm_sel_next, ifm_enable_write_next, ifm_address_write_next, data_out_for_next
  );
endinterface

// File: rtl/poolb3_consumer.sv
// 2x2/stride-2 max-pool between layer memories: 6 cycles per output pixel, frame waits while the next layer is busy.
// `POOL_RELU_EN clamps negative pooled values to zero without changing timing.
module poolb3_consumer #(
  parameter int ARITH_TYPE = 0,
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE   = 10,
  parameter int IFM_DEPTH  = 16
) (
  input logic               clk,
  input logic               reset,
  poolb3_consumer_if.master bus
);
  localparam int IFM_SIZE_NEXT = IFM_SIZE / 2;
  localparam int ADDR_PREV     = $clog2(IFM_SIZE * IFM_SIZE);
  localparam int ADDR_NEXT_RAW = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT);
  localparam int ADDR_NEXT     = (ADDR_NEXT_RAW > 0) ? ADDR_NEXT_RAW : 1;
  localparam int SEL_W         = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
  localparam int IW            = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(IFM_SIZE_NEXT - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(IFM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT_NEXT, WINDOW, DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cyc_q, cyc_d;
  logic [IW-1:0]         i_q, i_d, j_q, j_d;
  logic [SEL_W-1:0]      ch_q, ch_d;
  logic                  pending_q, pending_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [ADDR_PREV-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_NEXT-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_dat_q, wr_dat_d;
  logic                  rd_en, wr_en;
  logic [DATA_WIDTH-1:0] pooled;

  // Float ordering on sign-magnitude; both zeros compare equal so the first one seen is kept.
  function automatic logic greater(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (ARITH_TYPE == 1) return $signed(a) > $signed(b);
    if (a[DATA_WIDTH-2:0] == '0 && b[DATA_WIDTH-2:0] == '0) return 1'b0;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) return !a[DATA_WIDTH-1];
    if (a[DATA_WIDTH-1]) return a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
    return a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
  endfunction

  assign rd_en = (state_q == WINDOW) && !cyc_q[2];
  assign wr_en = (state_q == WINDOW) && (cyc_q == 3'd5);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    i_d       = i_q;
    j_d       = j_q;
    ch_d      = ch_q;
    max_d     = max_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    if (bus.start_from_previous && state_q != IDLE) pending_d = 1'b1;
    if (bus.end_from_next) busy_d = 1'b0;
    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (bus.start_from_previous || pending_q) state_d = WAIT_NEXT;
      end
      WAIT_NEXT: begin
        if (!busy_q) begin
          state_d = WINDOW;
          cyc_d   = '0;
        end
      end
      WINDOW: begin
        if (cyc_q == 3'd1) max_d = bus.data_in_from_previous;
        else if (cyc_q >= 3'd2 && cyc_q <= 3'd4 && greater(bus.data_in_from_previous, max_q))
          max_d = bus.data_in_from_previous;
        if (cyc_q == 3'd5) begin
          cyc_d = '0;
          j_d   = j_q + 1'b1;
          if (j_q == LAST_IDX) begin
            j_d = '0;
            i_d = i_q + 1'b1;
            if (i_q == LAST_IDX) begin
              i_d  = '0;
              ch_d = ch_q + 1'b1;
              if (ch_q == LAST_CH) begin
                ch_d    = '0;
                state_d = DONE;
              end
            end
          end
        end else begin
          cyc_d = cyc_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Addresses and data are held between strobes rather than tracking the counters.
  always_comb begin
    pooled = max_q;
`ifdef POOL_RELU_EN
    if (max_q[DATA_WIDTH-1]) pooled = '0;
`endif
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    if (rd_en)
      rd_addr_d = ADDR_PREV'((2 * int'(i_q) + int'(cyc_q[1])) * IFM_SIZE + 2 * int'(j_q) + int'(cyc_q[0]));
    if (wr_en) begin
      wr_addr_d = ADDR_NEXT'(int'(i_q) * IFM_SIZE_NEXT + int'(j_q));
      wr_dat_d  = pooled;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      ch_q      <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      max_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      i_q       <= i_d;
      j_q       <= j_d;
      ch_q      <= ch_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      max_q     <= max_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
    end
  end

  assign bus.end_to_previous           = (state_q == DONE);
  assign bus.start_to_next             = (state_q == DONE);
  assign bus.ifm_sel_previous          = ch_q;
  assign bus.ifm_sel_next              = ch_q;
  assign bus.ifm_enable_read_previous  = rd_en;
  assign bus.ifm_address_read_previous = rd_addr_d;
  assign bus.ifm_enable_write_next     = wr_en;
  assign bus.ifm_address_write_next    = wr_addr_d;
  assign bus.data_out_for_next         = wr_dat_d;
endmodule

// File: tb/tb_poolb3_consumer.sv
// Scoreboard bench: two DUTs (signed 4x4x1 and float 5x5x2) with memory models; monitors pop expected writes/pulses.
module tb_poolb3_consumer;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef POOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  poolb3_consumer_if #(.DATA_WIDTH(32), .IFM_SIZE(4), .IFM_DEPTH(1)) bi ();
  poolb3_consumer_if #(.DATA_WIDTH(32), .IFM_SIZE(5), .IFM_DEPTH(2)) bf ();

  poolb3_consumer #(.ARITH_TYPE(1), .DATA_WIDTH(32), .IFM_SIZE(4), .IFM_DEPTH(1)) dut_i (
    .clk(clk), .reset(rst_n), .bus(bi));
  poolb3_consumer #(.ARITH_TYPE(0), .DATA_WIDTH(32), .IFM_SIZE(5), .IFM_DEPTH(2)) dut_f (
    .clk(clk), .reset(rst_n), .bus(bf));

  logic [31:0] mem_i [0:15];
  logic [31:0] mem_f [0:1][0:31];

  always @(posedge clk) begin
    if (bi.ifm_enable_read_previous) bi.data_in_from_previous <= mem_i[bi.ifm_address_read_previous];
    if (bf.ifm_enable_read_previous)
      bf.data_in_from_previous <= mem_f[bf.ifm_sel_previous][bf.ifm_address_read_previous];
  end

  typedef struct { int ch; int addr; logic [31:0] data; } wr_t;
  wr_t exp_i[$];
  wr_t exp_f[$];
  int  pul_i[$];
  int  pul_f[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
    return (RELU && v[31]) ? 32'h0 : v;
  endfunction

  task automatic push_i(input int ch, input int addr, input logic [31:0] d);
    wr_t w;
    w.ch = ch; w.addr = addr; w.data = relu(d);
    exp_i.push_back(w);
  endtask

  task automatic push_f(input int ch, input int addr, input logic [31:0] d);
    wr_t w;
    w.ch = ch; w.addr = addr; w.data = relu(d);
    exp_f.push_back(w);
  endtask

  function automatic logic [63:0] outs_i();
    return 64'({bi.end_to_previous, bi.ifm_sel_previous, bi.ifm_enable_read_previous, bi.ifm_address_read_previous,
                bi.start_to_next, bi.ifm_sel_next, bi.ifm_enable_write_next, bi.ifm_address_write_next,
                bi.data_out_for_next});
  endfunction

  function automatic logic [63:0] outs_f();
    return 64'({bf.end_to_previous, bf.ifm_sel_previous, bf.ifm_enable_read_previous, bf.ifm_address_read_previous,
                bf.start_to_next, bf.ifm_sel_next, bf.ifm_enable_write_next, bf.ifm_address_write_next,
                bf.data_out_for_next});
  endfunction

  always @(negedge clk) begin : mon_i
    wr_t e;
    int  p;
    if (rst_n && bi.ifm_enable_write_next) begin
      if (exp_i.size() == 0) check("i_unexpected_write", 1, 0);
      else begin
        e = exp_i.pop_front();
        check("i_wr_data", 64'(bi.data_out_for_next), 64'(e.data));
        check("i_wr_addr", 64'(bi.ifm_address_write_next), 64'(e.addr));
        check("i_wr_sel", 64'(bi.ifm_sel_next), 64'(e.ch));
      end
    end
    if (rst_n && (bi.start_to_next || bi.end_to_previous)) begin
      check("i_pulse_pair", 64'({bi.start_to_next, bi.end_to_previous}), 64'(2'b11));
      if (pul_i.size() == 0) check("i_unexpected_pulse", 1, 0);
      else begin
        p = pul_i.pop_front();
        check("i_pulse_cycle", 64'(cyc), 64'(p));
      end
    end
  end

  always @(negedge clk) begin : mon_f
    wr_t e;
    int  p;
    if (rst_n && bf.ifm_enable_write_next) begin
      if (exp_f.size() == 0) check("f_unexpected_write", 1, 0);
      else begin
        e = exp_f.pop_front();
        check("f_wr_data", 64'(bf.data_out_for_next), 64'(e.data));
        check("f_wr_addr", 64'(bf.ifm_address_write_next), 64'(e.addr));
        check("f_wr_sel", 64'(bf.ifm_sel_next), 64'(e.ch));
      end
    end
    if (rst_n && (bf.start_to_next || bf.end_to_previous)) begin
      check("f_pulse_pair", 64'({bf.start_to_next, bf.end_to_previous}), 64'(2'b11));
      if (pul_f.size() == 0) check("f_unexpected_pulse", 1, 0);
      else begin
        p = pul_f.pop_front();
        check("f_pulse_cycle", 64'(cyc), 64'(p));
      end
    end
  end

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_i.size() + exp_f.size() + pul_i.size() + pul_f.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_i.size() + exp_f.size() + pul_i.size() + pul_f.size()), 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  t;
    int  s;
    logic rd_seen;
    rst_n = 1'b0;
    bi.start_from_previous = 1'b0; bi.end_from_next = 1'b0;
    bf.start_from_previous = 1'b0; bf.end_from_next = 1'b0;
    for (int a = 0; a < 16; a++) mem_i[a] = 32'(a + 1);
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 32; a++)
        mem_f[c][a] = (a % 5 == 4 || a >= 20) ? 32'h47000000 : (c == 0 ? 32'h3F800000 : 32'hC0400000);
    mem_f[0][0]  = 32'hBF800000; mem_f[0][1]  = 32'h3F000000; mem_f[0][5]  = 32'hC0000000; mem_f[0][6]  = 32'h80000000;
    mem_f[0][2]  = 32'h80000000; mem_f[0][3]  = 32'h00000000; mem_f[0][7]  = 32'hBF800000; mem_f[0][8]  = 32'h80000000;
    mem_f[0][10] = 32'hC0000000; mem_f[0][11] = 32'hBF800000; mem_f[0][15] = 32'hC0400000; mem_f[0][16] = 32'hBF000000;
    mem_f[1][18] = 32'hC0A00000;

    repeat (3) @(negedge clk);
    check("i_reset_outputs", outs_i(), 0);
    check("f_reset_outputs", outs_f(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ascending 4x4 ramp, signed compare; pulses 26 cycles after start
    push_i(0, 0, 32'd6); push_i(0, 1, 32'd8); push_i(0, 2, 32'd14); push_i(0, 3, 32'd16);
    pul_i.push_back(cyc + 26);
    bi.start_from_previous = 1'b1;
    @(negedge clk);
    bi.start_from_previous = 1'b0;
    drain(100, "i_frame1_drain");

    // next layer still busy: start must wait for end_from_next
    for (int a = 0; a < 16; a++) mem_i[a] = 32'hFFFFFFF9;
    for (int k = 0; k < 4; k++) push_i(0, k, 32'hFFFFFFF9);
    bi.start_from_previous = 1'b1;
    @(negedge clk);
    bi.start_from_previous = 1'b0;
    rd_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      rd_seen |= bi.ifm_enable_read_previous;
    end
    check("i_hold_while_next_busy", 64'(rd_seen), 0);
    t = cyc;
    pul_i.push_back(t + 26);
    bi.end_from_next = 1'b1;
    @(negedge clk);
    bi.end_from_next = 1'b0;
    check("i_no_read_1_after_end", 64'(bi.ifm_enable_read_previous), 0);
    @(negedge clk);
    check("i_first_read_2_after_end", 64'(bi.ifm_enable_read_previous), 1);
    check("i_first_read_addr", 64'(bi.ifm_address_read_previous), 0);

    // start during WINDOW is remembered; second frame waits for the next end_from_next
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) push_i(0, k, 32'hFFFFFFF9);
    bi.start_from_previous = 1'b1;
    @(negedge clk);
    bi.start_from_previous = 1'b0;
    rd_seen = 1'b0;
    while (cyc < t + 30) begin
      @(negedge clk);
      if (cyc > t + 26) rd_seen |= bi.ifm_enable_read_previous;
    end
    check("i_pending_waits_for_next", 64'(rd_seen), 0);
    pul_i.push_back(cyc + 26);
    bi.end_from_next = 1'b1;
    @(negedge clk);
    bi.end_from_next = 1'b0;
    drain(100, "i_pending_frame_drain");

    // abort the float DUT mid-window with reset
    s = cyc;
    bf.start_from_previous = 1'b1;
    @(negedge clk);
    bf.start_from_previous = 1'b0;
    while (cyc < s + 4) @(negedge clk);
    check("f_mid_window_reading", 64'(bf.ifm_enable_read_previous), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("f_reset_mid_window", outs_f(), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // full float frame on 5x5x2: last row/col (32768.0) must be dropped
    push_f(0, 0, 32'h3F000000); push_f(0, 1, 32'h80000000); push_f(0, 2, 32'hBF000000); push_f(0, 3, 32'h3F800000);
    for (int k = 0; k < 4; k++) push_f(1, k, 32'hC0400000);
    pul_f.push_back(cyc + 50);
    bf.start_from_previous = 1'b1;
    @(negedge clk);
    bf.start_from_previous = 1'b0;
    drain(200, "f_frame_drain");

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
